var_delay_line: RTL and testbench

- Runtime-programmable sample delay with a clock enable. Holds a circular buffer of up to MAX_DELAY samples.
- Matches the delay-line semantics used elsewhere in the design: each ce edge is one step of the line.
- The tap is selected by a `delay` input instead of an elaboration-time constant.
- Sits on datapaths that need alignment to an upstream latency only known at run time. Reports when the output carries real history.

---
 rtl/var_delay_pkg.sv | 29 ++
 rtl/var_delay_line_ram.sv | 27 ++
 rtl/var_delay_line.sv | 92 +++++++++
 tb/tb_var_delay_line.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/var_delay_pkg.sv
// Width helpers for var_delay_line: delay-port and storage-address widths derived from MAX_DELAY.
// Pure elaboration-time functions; no logic, latency or backpressure.
package var_delay_pkg;

  localparam int DEFAULT_N         = 5;
  localparam int DEFAULT_MAX_DELAY = 16;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of the delay port: must represent 0..MAX_DELAY and beyond for error detection.
  function automatic int delay_width(input int max_delay);
    return clog2(max_delay + 1);
  endfunction

  function automatic int addr_width(input int max_delay);
    return clog2(max_delay);
  endfunction

endpackage

// File: rtl/var_delay_line_ram.sv
// MAX_DELAY x N register array, one write port and an asynchronous read port.
// Write lands on the rising edge when we=1; read is combinational; no backpressure.
module var_delay_line_ram #(
  parameter int N     = 5,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  // Contents are never reset; the fill count in the parent masks stale entries.
  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/var_delay_line.sv
// Runtime-programmable ce-gated delay line (0..MAX_DELAY steps); delay 0 is zero-latency pass-through, else tap is combinational from storage.
// No backpressure: ce alone advances state. Option VAR_DELAY_FLUSH_ON_CHANGE_EN restarts the fill count whenever the clamped delay changes.
module var_delay_line
  import var_delay_pkg::*;
#(
  parameter  int N         = DEFAULT_N,
  parameter  int MAX_DELAY = DEFAULT_MAX_DELAY,
  localparam int DW        = delay_width(MAX_DELAY)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [N-1:0]  idata,
  input  logic [DW-1:0] delay,
  output logic [N-1:0]  odata,
  output logic          ovalid,
  output logic          delay_err
);

  localparam int              AW    = addr_width(MAX_DELAY);
  localparam logic [DW-1:0]   MAX_D = DW'(MAX_DELAY);
  localparam logic [AW:0]     MAX_A = (AW+1)'(MAX_DELAY);

  logic [AW-1:0] r_wp;
  logic [DW-1:0] r_fill;
  logic [DW-1:0] r_delay_q;
  logic          r_delay_err;

  logic          w_over;
  logic [DW-1:0] w_delay_clamped;
  logic          w_flush;
  logic [AW-1:0] w_wp_next;
  logic [AW:0]   w_diff;
  logic [AW-1:0] w_raddr;
  logic [N-1:0]  w_rdata;
  logic          w_valid;

  assign w_over          = (delay > MAX_D);
  assign w_delay_clamped = w_over ? MAX_D : delay;

`ifdef VAR_DELAY_FLUSH_ON_CHANGE_EN
  assign w_flush = (w_delay_clamped != r_delay_q);
`else
  assign w_flush = 1'b0;
`endif

  assign w_wp_next = (r_wp == AW'(MAX_DELAY - 1)) ? '0 : r_wp + 1'b1;

  // (wp - d) mod MAX_DELAY via wp + MAX_DELAY - d, which stays below 2*MAX_DELAY.
  assign w_diff  = {1'b0, r_wp} + MAX_A - (AW+1)'(r_delay_q);
  assign w_raddr = (w_diff >= MAX_A) ? AW'(w_diff - MAX_A) : AW'(w_diff);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp        <= '0;
      r_fill      <= '0;
      r_delay_q   <= '0;
      r_delay_err <= 1'b0;
    end else if (ce) begin
      r_wp      <= w_wp_next;
      r_delay_q <= w_delay_clamped;
      if (w_over) begin
        r_delay_err <= 1'b1;
      end
      if (w_flush) begin
        r_fill <= '0;
      end else if (r_fill != MAX_D) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  var_delay_line_ram #(
    .N     (N),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ce),
    .waddr (r_wp),
    .wdata (idata),
    .raddr (w_raddr),
    .rdata (w_rdata)
  );

  // With d = MAX_DELAY the tap is the slot being overwritten; async read sees the old value.
  assign w_valid   = (r_delay_q == '0) || (r_fill >= r_delay_q);
  assign ovalid    = w_valid;
  assign odata     = (r_delay_q == '0) ? idata : (w_valid ? w_rdata : '0);
  assign delay_err = r_delay_err;

endmodule

// File: tb/tb_var_delay_line.sv
// Scoreboarded random/directed bench for var_delay_line against a sample-history reference model.
// Driver pushes expected outputs per cycle; a monitor pops and compares after inputs settle.
module tb_var_delay_line;

  localparam int N         = 5;
  localparam int MAX_DELAY = 16;
  localparam int DW        = $clog2(MAX_DELAY + 1);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce    = 1'b0;
  logic [N-1:0]  idata = '0;
  logic [DW-1:0] delay = '0;
  logic [N-1:0]  odata;
  logic          ovalid;
  logic          delay_err;

  var_delay_line #(
    .N         (N),
    .MAX_DELAY (MAX_DELAY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .idata     (idata),
    .delay     (delay),
    .odata     (odata),
    .ovalid    (ovalid),
    .delay_err (delay_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] odata;
    logic         ovalid;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model: every sample accepted on a ce edge, newest at the back.
  logic [N-1:0] hist[$];
  int           m_fill = 0;
  int           m_dq   = 0;
  bit           m_err  = 1'b0;

  task automatic step(input bit rst, input bit c, input logic [N-1:0] d_in, input int dl);
    exp_t e;
    int   cl;
    bit   flush;
    @(negedge clk);
    rst_n = rst;
    ce    = c;
    idata = d_in;
    delay = DW'(dl);
    if (!rst) begin
      hist.delete();
      m_fill = 0;
      m_dq   = 0;
      m_err  = 1'b0;
    end
    e.err = m_err;
    if (m_dq == 0) begin
      e.odata  = d_in;
      e.ovalid = 1'b1;
    end else begin
      e.ovalid = (m_fill >= m_dq);
      e.odata  = e.ovalid ? hist[hist.size() - m_dq] : '0;
    end
    exp_q.push_back(e);
    if (rst && c) begin
      cl    = (dl > MAX_DELAY) ? MAX_DELAY : dl;
      flush = 1'b0;
      if (dl > MAX_DELAY) m_err = 1'b1;
`ifdef VAR_DELAY_FLUSH_ON_CHANGE_EN
      flush = (cl != m_dq);
`endif
      if (flush) m_fill = 0;
      else       m_fill = (m_fill < MAX_DELAY) ? m_fill + 1 : MAX_DELAY;
      m_dq = cl;
      hist.push_back(d_in);
      if (hist.size() > 64) void'(hist.pop_front());
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      checks = checks + 3;
      if (odata !== mon_e.odata) begin
        errors = errors + 1;
        $display("FAIL odata t=%0t got=%h exp=%h", $time, odata, mon_e.odata);
      end
      if (ovalid !== mon_e.ovalid) begin
        errors = errors + 1;
        $display("FAIL ovalid t=%0t got=%b exp=%b", $time, ovalid, mon_e.ovalid);
      end
      if (delay_err !== mon_e.err) begin
        errors = errors + 1;
        $display("FAIL delay_err t=%0t got=%b exp=%b", $time, delay_err, mon_e.err);
      end
    end
  end

  initial begin
    int cur_delay;
    int cnt;

    // Reset state and pass-through with no ce.
    step(1'b0, 1'b0, 5'h1A, 0);
    step(1'b0, 1'b1, 5'h1A, 0);
    step(1'b1, 1'b0, 5'h1A, 0);
    step(1'b1, 1'b0, 5'h07, 0);

    // Delay 4 ramp.
    for (int i = 1; i <= 20; i++) step(1'b1, 1'b1, N'(i), 4);

    // Delay 16 across two wraps.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, N'(i + 3), 16);

    // Fresh line, delay 4, then ce toggling.
    step(1'b0, 1'b0, '0, 4);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, N'(i + 1), 4);
    for (int i = 0; i < 20; i++) step(1'b1, ((i % 2) == 0), N'(i + 11), 4);

    // Mid-stream change 4 -> 2.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, N'(i + 7), 2);

    // Out-of-range delay, sticky error, cleared only by reset.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, N'(i + 20), 20);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, N'(i + 2), 3);
    step(1'b0, 1'b0, 5'h15, 3);
    step(1'b1, 1'b0, 5'h0C, 3);
    step(1'b1, 1'b1, 5'h0D, 3);

    // Randomized traffic with occasional delay changes, overflows and resets.
    cur_delay = 5;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        cnt = $urandom_range(0, 9);
        cur_delay = (cnt == 0) ? $urandom_range(0, 31) : $urandom_range(0, MAX_DELAY);
      end
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
           N'($urandom_range(0, 31)), cur_delay);
    end

    cnt = 0;
    while (exp_q.size() > 0 && cnt < 10) begin
      @(negedge clk);
      cnt = cnt + 1;
    end
    #5;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
